// File: rtl/params_pkg.sv
// Shared widths and FSM state type for the data cache.
package params_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StWrite
  } dcache_state_t;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid/tag/data per line, one async read port, one sync write port.
module dcache_array #(
  parameter int unsigned NUM_LINES  = 8,
  parameter int unsigned TAG_WIDTH  = 29,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned IdxWidth  = $clog2(NUM_LINES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IdxWidth-1:0]   rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_WIDTH-1:0]  rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [IdxWidth-1:0]   wr_idx_i,
  input  logic [TAG_WIDTH-1:0]  wr_tag_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset; the valid bit qualifies them.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Define DCACHE_STATS_EN to add hit_count_o/miss_count_o counters.
module dcache
  import params_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int unsigned NUM_LINES  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  req_ready_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o,
`endif
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned IdxWidth = $clog2(NUM_LINES);
  localparam int unsigned TagWidth = ADDR_WIDTH - IdxWidth;

  dcache_state_t         state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  rd_valid;
  logic [TagWidth-1:0]   rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [IdxWidth-1:0]   wr_idx;
  logic [TagWidth-1:0]   wr_tag;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  accept, hit;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_WIDTH (TagWidth),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_idx_i  (req_addr_i[IdxWidth-1:0]),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en & ~rst_i),
    .wr_idx_i  (wr_idx),
    .wr_tag_i  (wr_tag),
    .wr_data_i (wr_data)
  );

  assign accept = req_valid_i && (state_q == StIdle);
  assign hit    = rd_valid && (rd_tag == req_addr_i[ADDR_WIDTH-1:IdxWidth]);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    wr_en       = 1'b0;
    wr_idx      = req_addr_i[IdxWidth-1:0];
    wr_tag      = req_addr_i[ADDR_WIDTH-1:IdxWidth];
    wr_data     = req_wdata_i;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (req_we_i) begin
            // Write-through: update a hitting line now, never allocate on a miss.
            wr_en       = hit;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_addr_i;
            mem_wdata_d = req_wdata_i;
            state_d     = StWrite;
          end else if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_data;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = req_addr_i;
            state_d    = StRefill;
          end
        end
      end
      StRefill: begin
        wr_idx = mem_addr_q[IdxWidth-1:0];
        wr_tag = mem_addr_q[ADDR_WIDTH-1:IdxWidth];
        wr_data = mem_rdata_i;
        if (mem_req_q && mem_ack_i) begin
          wr_en       = 1'b1;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rdata_i;
          state_d     = StIdle;
        end
      end
      StWrite: begin
        if (mem_req_q && mem_ack_i) begin
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (accept) begin
      if (hit) hit_count_q <= hit_count_q + 32'd1;
      else     miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
